// File: rtl/tdm_pkg.sv
// Shared types and default sizing for the TDM demultiplexer.
package tdm_pkg;

  localparam int unsigned NCH_DEF = 4;
  localparam int unsigned W_DEF   = 8;
  localparam int unsigned SEL_W   = $clog2(NCH_DEF);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

endpackage

// File: rtl/tdm_demux_decoder.sv
// Gated one-hot decoder: turns a channel index into shadow-register write enables.
module demux_decoder #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic [SEL_W-1:0] sel_i,
  input  logic             en_i,
  output logic [NCH-1:0]   we_c
);

  always_comb begin
    we_c = '0;
    if (en_i) we_c[sel_i] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux.sv
// Serial-to-parallel TDM demultiplexer: collects NCH words per frame and
// publishes them atomically, flagging frames cut short by an early marker.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEF,
  parameter int unsigned W   = W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [W-1:0]             din,
  input  logic                     din_valid,
  input  logic                     frame_start,
  output logic [NCH*W-1:0]         ch_data,
  output logic                     frame_valid,
  output logic [$clog2(NCH)-1:0]   ch_sel,
  output logic                     frame_err
);

  localparam int unsigned SW = $clog2(NCH);
  localparam logic [SW-1:0] LAST_SEL = SW'(NCH - 1);

  state_e          state_q, state_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic            fv_q, fv_d;
  logic            fe_q, fe_d;
  logic            load_out;
  logic [W-1:0]    shadow_q [NCH];
  logic [NCH*W-1:0] data_q;

  logic [SW-1:0]   wr_sel;
  logic            wr_en;
  logic [NCH-1:0]  we;

  // A frame marker always restarts at slot 0; stray words in IDLE are dropped.
  assign wr_sel = frame_start ? '0 : sel_q;
  assign wr_en  = din_valid & (frame_start | (state_q == COLLECT));

  demux_decoder #(
    .NCH   (NCH),
    .SEL_W (SW)
  ) u_dec (
    .sel_i (wr_sel),
    .en_i  (wr_en),
    .we_c  (we)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      fv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      fv_q    <= fv_d;
      fe_q    <= fe_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    fv_d     = 1'b0;
    fe_d     = 1'b0;
    load_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (din_valid && frame_start) begin
          sel_d   = SW'(1);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (din_valid) begin
          if (frame_start) begin
            fe_d  = 1'b1;
            sel_d = SW'(1);
          end else if (sel_q == LAST_SEL) begin
            load_out = 1'b1;
            fv_d     = 1'b1;
            sel_d    = '0;
            state_d  = IDLE;
          end else begin
            sel_d = sel_q + SW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
  end

  // Shadow bank plus output bank; the last word bypasses its shadow slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) shadow_q[k] <= '0;
      data_q <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (we[k]) shadow_q[k] <= din;
      end
      if (load_out) begin
        for (int k = 0; k < NCH - 1; k++) data_q[k*W +: W] <= shadow_q[k];
        data_q[(NCH-1)*W +: W] <= din;
      end
    end
  end

  assign ch_data     = data_q;
  assign frame_valid = fv_q;
  assign frame_err   = fe_q;
  assign ch_sel      = sel_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed self-checking bench for tdm_demux with NCH=4, W=8.
module tb_tdm_demux;

  localparam int unsigned NCH = 4;
  localparam int unsigned W   = 8;

  logic             clk;
  logic             rst_n;
  logic [W-1:0]     din;
  logic             din_valid;
  logic             frame_start;
  logic [NCH*W-1:0] ch_data;
  logic             frame_valid;
  logic [1:0]       ch_sel;
  logic             frame_err;

  int errors = 0;
  int checks = 0;

  tdm_demux #(.NCH(NCH), .W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .frame_start (frame_start),
    .ch_data     (ch_data),
    .frame_valid (frame_valid),
    .ch_sel      (ch_sel),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of input, then return to 1 time unit after the edge.
  task automatic beat(input logic v, input logic fs, input logic [W-1:0] d);
    din_valid   = v;
    frame_start = fs;
    din         = d;
    @(posedge clk);
    #1;
    din_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (ch_data !== 32'h0) begin
      errors++; $display("FAIL reset_ch_data: got %h want %h", ch_data, 32'h0);
    end
    checks++;
    if (ch_sel !== 2'd0) begin
      errors++; $display("FAIL reset_ch_sel: got %0d want 0", ch_sel);
    end
    checks++;
    if (frame_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL reset_strobes: got fv=%b fe=%b want 0 0", frame_valid, frame_err);
    end
  endtask

  task automatic test_normal();
    logic [W-1:0] words [4];
    logic [1:0]   exp_sel [4];
    words   = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_sel = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, i == 0, words[i]);
      checks++;
      if (ch_sel !== exp_sel[i]) begin
        errors++; $display("FAIL normal_ch_sel[%0d]: got %0d want %0d", i, ch_sel, exp_sel[i]);
      end
      checks++;
      if (frame_valid !== (i == 3)) begin
        errors++; $display("FAIL normal_fv[%0d]: got %b want %b", i, frame_valid, i == 3);
      end
    end
    checks++;
    if (ch_data !== 32'h44332211) begin
      errors++; $display("FAIL normal_ch_data: got %h want 44332211", ch_data);
    end
    beat(1'b0, 1'b0, 8'h00);
    checks++;
    if (frame_valid !== 1'b0 || ch_data !== 32'h44332211) begin
      errors++; $display("FAIL normal_after: got fv=%b data=%h want 0 44332211", frame_valid, ch_data);
    end
  endtask

  task automatic test_gaps();
    logic [W-1:0] words [4];
    int fv_count;
    int fv_last;
    words    = '{8'h55, 8'h66, 8'h77, 8'h88};
    fv_count = 0;
    fv_last  = 0;
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, i == 0, words[i]);
      if (frame_valid === 1'b1) begin
        fv_count++;
        if (i == 3) fv_last = 1;
      end
      for (int g = 0; g < 3; g++) begin
        beat(1'b0, 1'b0, 8'hxx);
        if (frame_valid === 1'b1) fv_count++;
        if (i < 3 && ch_data !== 32'h44332211) begin
          checks++;
          errors++; $display("FAIL gaps_hold: got %h want 44332211", ch_data);
        end
      end
    end
    checks++;
    if (fv_count !== 1 || fv_last !== 1) begin
      errors++; $display("FAIL gaps_fv_count: got count=%0d at_last=%0d want 1 1", fv_count, fv_last);
    end
    checks++;
    if (ch_data !== 32'h88776655) begin
      errors++; $display("FAIL gaps_ch_data: got %h want 88776655", ch_data);
    end
  endtask

  task automatic test_early_marker();
    beat(1'b1, 1'b1, 8'hA1);
    beat(1'b1, 1'b0, 8'hA2);
    beat(1'b1, 1'b1, 8'hB1);
    checks++;
    if (frame_err !== 1'b1 || frame_valid !== 1'b0) begin
      errors++; $display("FAIL early_err: got fe=%b fv=%b want 1 0", frame_err, frame_valid);
    end
    checks++;
    if (ch_data !== 32'h88776655 || ch_sel !== 2'd1) begin
      errors++; $display("FAIL early_hold: got data=%h sel=%0d want 88776655 1", ch_data, ch_sel);
    end
    beat(1'b1, 1'b0, 8'hB2);
    checks++;
    if (frame_err !== 1'b0) begin
      errors++; $display("FAIL early_err_pulse: got fe=%b want 0", frame_err);
    end
    beat(1'b1, 1'b0, 8'hB3);
    beat(1'b1, 1'b0, 8'hB4);
    checks++;
    if (frame_valid !== 1'b1 || ch_data !== 32'hB4B3B2B1) begin
      errors++; $display("FAIL early_done: got fv=%b data=%h want 1 b4b3b2b1", frame_valid, ch_data);
    end
    // Abort exactly when the last slot is pending.
    beat(1'b1, 1'b1, 8'hC1);
    beat(1'b1, 1'b0, 8'hC2);
    beat(1'b1, 1'b0, 8'hC3);
    beat(1'b1, 1'b1, 8'hD1);
    checks++;
    if (frame_err !== 1'b1 || frame_valid !== 1'b0 || ch_sel !== 2'd1 || ch_data !== 32'hB4B3B2B1) begin
      errors++; $display("FAIL late_abort: got fe=%b fv=%b sel=%0d data=%h want 1 0 1 b4b3b2b1",
                         frame_err, frame_valid, ch_sel, ch_data);
    end
    beat(1'b1, 1'b0, 8'hD2);
    beat(1'b1, 1'b0, 8'hD3);
    beat(1'b1, 1'b0, 8'hD4);
    checks++;
    if (frame_valid !== 1'b1 || frame_err !== 1'b0 || ch_data !== 32'hD4D3D2D1) begin
      errors++; $display("FAIL late_abort_done: got fv=%b fe=%b data=%h want 1 0 d4d3d2d1",
                         frame_valid, frame_err, ch_data);
    end
  endtask

  task automatic test_idle_discard();
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    beat(1'b1, 1'b0, 8'hFF);
    beat(1'b1, 1'b0, 8'hEE);
    checks++;
    if (ch_sel !== 2'd0 || ch_data !== 32'h0 || frame_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL idle_discard: got sel=%0d data=%h fv=%b fe=%b want 0 0 0 0",
                         ch_sel, ch_data, frame_valid, frame_err);
    end
    beat(1'b1, 1'b1, 8'h01);
    beat(1'b1, 1'b0, 8'h02);
    beat(1'b1, 1'b0, 8'h03);
    beat(1'b1, 1'b0, 8'h04);
    checks++;
    if (frame_valid !== 1'b1 || ch_data !== 32'h04030201) begin
      errors++; $display("FAIL idle_then_frame: got fv=%b data=%h want 1 04030201", frame_valid, ch_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words [8];
    words = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23};
    for (int i = 0; i < 8; i++) begin
      beat(1'b1, (i % 4) == 0, words[i]);
      checks++;
      if (frame_valid !== ((i % 4) == 3)) begin
        errors++; $display("FAIL b2b_fv[%0d]: got %b want %b", i, frame_valid, (i % 4) == 3);
      end
      if (i == 3) begin
        checks++;
        if (ch_data !== 32'h13121110) begin
          errors++; $display("FAIL b2b_first: got %h want 13121110", ch_data);
        end
      end
    end
    checks++;
    if (ch_data !== 32'h23222120 || frame_err !== 1'b0) begin
      errors++; $display("FAIL b2b_second: got data=%h fe=%b want 23222120 0", ch_data, frame_err);
    end
  endtask

  task automatic test_reset_mid_frame();
    beat(1'b1, 1'b1, 8'h91);
    beat(1'b1, 1'b0, 8'h92);
    rst_n = 1'b0;
    #1;
    checks++;
    if (ch_data !== 32'h0 || ch_sel !== 2'd0 || frame_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got data=%h sel=%0d fv=%b fe=%b want 0 0 0 0",
                         ch_data, ch_sel, frame_valid, frame_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    beat(1'b1, 1'b0, 8'h93);
    beat(1'b1, 1'b0, 8'h94);
    checks++;
    if (frame_valid !== 1'b0 || ch_sel !== 2'd0) begin
      errors++; $display("FAIL mid_reset_no_frame: got fv=%b sel=%0d want 0 0", frame_valid, ch_sel);
    end
    beat(1'b1, 1'b1, 8'hE1);
    beat(1'b1, 1'b0, 8'hE2);
    beat(1'b1, 1'b0, 8'hE3);
    beat(1'b1, 1'b0, 8'hE4);
    checks++;
    if (frame_valid !== 1'b1 || ch_data !== 32'hE4E3E2E1) begin
      errors++; $display("FAIL mid_reset_frame: got fv=%b data=%h want 1 e4e3e2e1", frame_valid, ch_data);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    din         = '0;
    din_valid   = 1'b0;
    frame_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_normal();
    test_gaps();
    test_early_marker();
    test_idle_discard();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
